// File: rtl/axil_master.sv
// Single-outstanding AXI-Lite master: turns one req_* command into an AW/W/B or AR/R
// transaction and returns the result on rsp_*. Optional watchdog: AXIL_MASTER_TIMEOUT_EN.
module axil_master #(
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] mbus_awaddr,
  output logic              mbus_awvalid,
  input  logic              mbus_awready,
  output logic [31:0]       mbus_wdata,
  output logic [3:0]        mbus_wstrb,
  output logic              mbus_wvalid,
  input  logic              mbus_wready,
  input  logic [1:0]        mbus_bresp,
  input  logic              mbus_bvalid,
  output logic              mbus_bready,
  output logic [ADDR_W-1:0] mbus_araddr,
  output logic              mbus_arvalid,
  input  logic              mbus_arready,
  input  logic [31:0]       mbus_rdata,
  input  logic [1:0]        mbus_rresp,
  input  logic              mbus_rvalid,
  output logic              mbus_rready
);

  typedef enum logic [2:0] {IDLE, WR, WB, RD, RR, RSP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              abort;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;

  if (TIMEOUT < 1) begin : g_param_chk
    $error("axil_master: TIMEOUT must be at least 1");
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy;

  assign busy  = (state_q == WR) || (state_q == WB) || (state_q == RD) || (state_q == RR);
  assign abort = busy && (cnt_q == CW'(TIMEOUT));

  // Held at zero in IDLE, so every transaction starts counting from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)      cnt_d = '0;
    else if (busy && !abort)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  assign aw_hs = mbus_awvalid && mbus_awready;
  assign w_hs  = mbus_wvalid  && mbus_wready;
  assign b_hs  = mbus_bvalid  && mbus_bready;
  assign ar_hs = mbus_arvalid && mbus_arready;
  assign r_hs  = mbus_rvalid  && mbus_rready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        addr_d    = req_addr;
        wdata_d   = req_wdata;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = req_write ? WR : RD;
      end
      WR: begin
        // AW and W complete independently; leave once both have, in any order.
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WB;
      end
      WB: if (b_hs) begin
        resp_d  = mbus_bresp;
        rdata_d = '0;
        state_d = RSP;
      end
      RD: if (ar_hs) state_d = RR;
      RR: if (r_hs) begin
        resp_d  = mbus_rresp;
        rdata_d = mbus_rdata;
        state_d = RSP;
      end
      RSP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = RSP;
      resp_d  = 2'b11;
      rdata_d = '0;
    end
  end

  // Bus valids/readies are gated by abort so they drop in the cycle the watchdog fires.
  always_comb begin
    req_ready    = (state_q == IDLE);
    rsp_valid    = (state_q == RSP);
    mbus_awvalid = (state_q == WR) && !aw_done_q && !abort;
    mbus_wvalid  = (state_q == WR) && !w_done_q && !abort;
    mbus_bready  = (state_q == WB) && !abort;
    mbus_arvalid = (state_q == RD) && !abort;
    mbus_rready  = (state_q == RR) && !abort;
    mbus_wstrb   = mbus_wvalid ? 4'hF : 4'h0;
  end

  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign mbus_awaddr = addr_q;
  assign mbus_araddr = addr_q;
  assign mbus_wdata  = wdata_q;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: table of transactions against a delay-configurable
// AXI-Lite slave, plus sequences for back-pressure, watchdog and mid-transaction reset.
module tb_axil_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [1:0]  mbus_awaddr, mbus_araddr;
  logic        mbus_awvalid, mbus_awready, mbus_wvalid, mbus_wready;
  logic [31:0] mbus_wdata, mbus_rdata;
  logic [3:0]  mbus_wstrb;
  logic [1:0]  mbus_bresp, mbus_rresp;
  logic        mbus_bvalid, mbus_bready, mbus_arvalid, mbus_arready, mbus_rvalid, mbus_rready;

  always #5 clk = ~clk;

  axil_master #(.ADDR_W(2), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .mbus_awaddr(mbus_awaddr), .mbus_awvalid(mbus_awvalid), .mbus_awready(mbus_awready),
    .mbus_wdata(mbus_wdata), .mbus_wstrb(mbus_wstrb), .mbus_wvalid(mbus_wvalid),
    .mbus_wready(mbus_wready), .mbus_bresp(mbus_bresp), .mbus_bvalid(mbus_bvalid),
    .mbus_bready(mbus_bready), .mbus_araddr(mbus_araddr), .mbus_arvalid(mbus_arvalid),
    .mbus_arready(mbus_arready), .mbus_rdata(mbus_rdata), .mbus_rresp(mbus_rresp),
    .mbus_rvalid(mbus_rvalid), .mbus_rready(mbus_rready)
  );

  // ---------------- slave model ----------------
  int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic        silent;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, nb;
  logic        got_aw, got_w, got_ar, bv, rv;
  logic [1:0]  wa, ra;
  logic [31:0] wd;
  logic [31:0] mem [4];

  assign mbus_awready = !silent && mbus_awvalid && (aw_cnt >= aw_dly);
  assign mbus_wready  = !silent && mbus_wvalid  && (w_cnt  >= w_dly);
  assign mbus_arready = !silent && mbus_arvalid && (ar_cnt >= ar_dly);
  assign mbus_bvalid  = bv;
  assign mbus_bresp   = bv ? bresp_cfg : 2'b00;
  assign mbus_rvalid  = rv;
  assign mbus_rdata   = rv ? mem[ra] : 32'h0;
  assign mbus_rresp   = rv ? rresp_cfg : 2'b00;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; nb <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0; bv <= 1'b0; rv <= 1'b0;
      wa <= 2'd0; ra <= 2'd0; wd <= 32'h0;
      for (int i = 0; i < 4; i++) mem[i] <= 32'hA0A0_0000 + i;
    end else begin
      if (mbus_awvalid && !mbus_awready) aw_cnt <= aw_cnt + 1;
      if (mbus_awvalid && mbus_awready) begin got_aw <= 1'b1; wa <= mbus_awaddr; aw_cnt <= 0; end
      if (mbus_wvalid && !mbus_wready) w_cnt <= w_cnt + 1;
      if (mbus_wvalid && mbus_wready) begin got_w <= 1'b1; wd <= mbus_wdata; w_cnt <= 0; end
      if (got_aw && got_w && !bv) begin
        if (b_cnt >= b_dly) bv <= 1'b1;
        else b_cnt <= b_cnt + 1;
      end
      if (bv && mbus_bready) begin
        bv <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0; b_cnt <= 0;
        mem[wa] <= wd; nb <= nb + 1;
      end
      if (mbus_arvalid && !mbus_arready) ar_cnt <= ar_cnt + 1;
      if (mbus_arvalid && mbus_arready) begin got_ar <= 1'b1; ra <= mbus_araddr; ar_cnt <= 0; end
      if (got_ar && !rv) begin
        if (r_cnt >= r_dly) rv <= 1'b1;
        else r_cnt <= r_cnt + 1;
      end
      if (rv && mbus_rready) begin rv <= 1'b0; got_ar <= 1'b0; r_cnt <= 0; end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_slave(input int awd, input int wdl, input int bd, input int ard,
                           input int rd, input logic [1:0] br, input logic [1:0] rr);
    aw_dly = awd; w_dly = wdl; b_dly = bd; ar_dly = ard; r_dly = rd;
    bresp_cfg = br; rresp_cfg = rr;
  endtask

  task automatic txn(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic [1:0] rs, output logic both_first,
                     output int aw_only, output int rwait, output int nbd, output int gap,
                     output logic to);
    int n, hs, nb0;
    nb0 = nb; aw_only = 0; rwait = 0; hs = -100;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    both_first = mbus_awvalid && mbus_wvalid;
    n = 0;
    while (!rsp_valid && n < 100) begin
      if (mbus_awvalid && !mbus_wvalid) aw_only++;
      if (mbus_rready && !mbus_rvalid) rwait++;
      if ((mbus_bvalid && mbus_bready) || (mbus_rvalid && mbus_rready)) hs = n;
      @(negedge clk);
      n++;
    end
    gap = n - hs;
    to  = !rsp_valid;
    rd  = rsp_rdata;
    rs  = rsp_resp;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    nbd = nb - nb0;
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    int          awd, wdl, bd, ard, rd;
    logic [1:0]  br, rr;
    logic [31:0] er;
    logic [1:0]  es;
    logic        eao;
  } vec_t;

  vec_t vt [7];

  initial begin
    logic [31:0] rd, d0;
    logic [1:0]  rs, s0;
    logic        bf, to, ok;
    int          ao, rw, nbd, gap, n, awc;

    vt[0] = '{1'b1, 2'd1, 32'h0000_005A, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h0,         2'd0, 1'b0};
    vt[1] = '{1'b0, 2'd1, 32'h0,         0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h0000_005A, 2'd0, 1'b0};
    vt[2] = '{1'b0, 2'd2, 32'h0,         0, 0, 0, 0, 3, 2'd0, 2'd0, 32'hA0A0_0002, 2'd0, 1'b0};
    vt[3] = '{1'b1, 2'd3, 32'hDEAD_BEEF, 2, 0, 1, 0, 0, 2'd2, 2'd0, 32'h0,         2'd2, 1'b1};
    vt[4] = '{1'b0, 2'd3, 32'h0,         0, 0, 0, 2, 0, 2'd0, 2'd1, 32'hDEAD_BEEF, 2'd1, 1'b0};
    vt[5] = '{1'b1, 2'd0, 32'h0000_1234, 0, 3, 0, 0, 0, 2'd0, 2'd0, 32'h0,         2'd0, 1'b0};
    vt[6] = '{1'b0, 2'd0, 32'h0,         0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h0000_1234, 2'd0, 1'b0};

    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_wdata = 32'h0;
    rsp_ready = 1'b0; silent = 1'b0;
    set_slave(0, 0, 0, 0, 0, 2'd0, 2'd0);
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_valids", {mbus_awvalid, mbus_wvalid, mbus_arvalid, mbus_bready, mbus_rready}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_resp", rsp_resp, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    for (int i = 0; i < 7; i++) begin
      set_slave(vt[i].awd, vt[i].wdl, vt[i].bd, vt[i].ard, vt[i].rd, vt[i].br, vt[i].rr);
      txn(vt[i].w, vt[i].a, vt[i].d, rd, rs, bf, ao, rw, nbd, gap, to);
      chk($sformatf("v%0d_timeout", i), to, 0);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].er);
      chk($sformatf("v%0d_resp", i), rs, vt[i].es);
      chk($sformatf("v%0d_rsp_gap", i), gap, 1);
      if (vt[i].w) begin
        chk($sformatf("v%0d_aw_w_together", i), bf, 1);
        chk($sformatf("v%0d_one_b", i), nbd, 1);
        chk($sformatf("v%0d_w_drop_aw_held", i), ao > 0, vt[i].eao);
      end
      if (vt[i].rd > 0) chk($sformatf("v%0d_rready_held", i), rw >= 3, 1);
    end

    // rsp back-pressure: response must stay put and a second command must be refused
    set_slave(0, 0, 0, 0, 0, 2'd0, 2'd0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_rsp_seen", rsp_valid, 1);
    d0 = rsp_rdata; s0 = rsp_resp;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 32'hFFFF_FFFF;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== d0 || rsp_resp !== s0 || req_ready || mbus_awvalid) ok = 1'b0;
    end
    chk("bp_stable", ok, 1);
    chk("bp_data", d0, 32'h0000_005A);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_req_ready_after", req_ready, 1);
    chk("bp_no_second_cmd", {rsp_valid, mbus_awvalid, mbus_arvalid}, 0);

    // silent slave: watchdog abort when enabled, otherwise stuck in WR
    silent = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 32'h1111_2222;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0; awc = 0;
    while (!rsp_valid && n < 40) begin
      if (mbus_awvalid) awc++;
      @(negedge clk);
      n++;
    end
`ifdef AXIL_MASTER_TIMEOUT_EN
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_wait_cycles", awc, 4);
    chk("to_resp", rsp_resp, 2'b11);
    chk("to_rdata", rsp_rdata, 0);
    chk("to_bus_idle", {mbus_awvalid, mbus_wvalid, mbus_bready}, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("to_req_ready", req_ready, 1);
`else
    chk("nto_no_rsp", rsp_valid, 0);
    chk("nto_still_wr", {mbus_awvalid, mbus_wvalid}, 2'b11);
    chk("nto_wait_cycles", awc, 40);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("nto_req_ready", req_ready, 1);
`endif
    silent = 1'b0;

    // reset while waiting in RR
    set_slave(0, 0, 0, 0, 10, 2'd0, 2'd0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mbus_rready && n < 20) begin @(negedge clk); n++; end
    chk("rr_reached", mbus_rready, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rr_rst_rready", mbus_rready, 0);
    chk("rr_rst_rsp_valid", rsp_valid, 0);
    chk("rr_rst_rdata", rsp_rdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rr_rel_req_ready", req_ready, 1);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid || mbus_arvalid || mbus_rready) ok = 1'b0;
    end
    chk("rr_abandoned", ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
